// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared segment constants, scan FSM encoding and frame helper
package seg_scan_driver_pkg;

  localparam int SEG_A_BIT  = 6;
  localparam int SEG_G_BIT  = 0;
  localparam int SEG_W      = SEG_A_BIT - SEG_G_BIT + 1;
  localparam int MAX_DIGITS = 8;
  localparam int FRAME_MAX_W = SEG_W * MAX_DIGITS;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Digit k occupies bits [7k+6:7k]; frames narrower than MAX_DIGITS are zero-extended.
  function automatic logic [SEG_W-1:0] seg_pick(input logic [FRAME_MAX_W-1:0] frame,
                                                input logic [2:0] k);
    return frame[SEG_W*k +: SEG_W];
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - frame load bus between the segment encoders and the scanner
interface seg_scan_driver_if
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                        load;
  logic [SEG_W*NUM_DIGITS-1:0] seg_in;
  logic                        pending;

  modport master (
    output load,
    output seg_in,
    input  pending
  );

  modport slave (
    input  load,
    input  seg_in,
    output pending
  );

endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - slot counter and digit index; freezes while en is low
module seg_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int CNT_W = $clog2(DIGIT_CYCLES),
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             frame_head,
  output logic             slot_end,
  output logic             frame_wrap,
  output logic             in_blank
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    slot_end   = en && (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
    frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Looks at the upcoming position so the FSM can register the matching state.
    in_blank = 32'(cnt_d) < 32'(BLANK_CYCLES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx        = idx_q;
  assign frame_head = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered 7-segment scanner with tear-free frame commit
// SEG_SCAN_DRIVER_BLANK_EN enables the per-slot anti-ghosting BLANK window.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  seg_scan_driver_if.slave      frm,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

`ifdef SEG_SCAN_DRIVER_BLANK_EN
  localparam int BLANK_EFF = BLANK_CYCLES;
`else
  localparam int BLANK_EFF = 0;
`endif

  localparam int FRAME_W = SEG_W * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam scan_state_e RST_STATE = (BLANK_EFF > 0) ? ST_BLANK : ST_SHOW;

  logic [IDX_W-1:0] idx;
  logic             frame_head;
  logic             slot_end;
  logic             frame_wrap;
  logic             in_blank;

  seg_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_EFF)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .idx        (idx),
    .frame_head (frame_head),
    .slot_end   (slot_end),
    .frame_wrap (frame_wrap),
    .in_blank   (in_blank)
  );

  logic [FRAME_W-1:0]    pend_buf_q, pend_buf_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [FRAME_W-1:0]    active_q, active_d;
  scan_state_e           state_q, state_d;
  logic [SEG_W-1:0]      seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_start_q, frame_start_d;

  always_comb begin
    // Commit consumes the old pending data; a coincident load refills the buffer.
    pend_buf_d  = frm.load ? frm.seg_in : pend_buf_q;
    pend_flag_d = frm.load | (pend_flag_q & ~frame_wrap);
    active_d    = (frame_wrap && pend_flag_q) ? pend_buf_q : active_q;

    state_d = state_q;
    if (en) begin
      unique case (state_q)
        ST_BLANK: state_d = in_blank ? ST_BLANK : ST_SHOW;
        ST_SHOW:  state_d = (slot_end && in_blank) ? ST_BLANK : ST_SHOW;
        default:  state_d = RST_STATE;
      endcase
    end

    seg_out_d     = SEG_BLANK;
    an_n_d        = '1;
    frame_start_d = 1'b0;
    if (en) begin
      frame_start_d = frame_head;
      if (state_q == ST_SHOW) begin
        seg_out_d = seg_pick(FRAME_MAX_W'(active_q), 3'(idx));
        an_n_d    = ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_buf_q    <= '0;
      pend_flag_q   <= 1'b0;
      active_q      <= '0;
      state_q       <= RST_STATE;
      seg_out_q     <= SEG_BLANK;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pend_buf_q    <= pend_buf_d;
      pend_flag_q   <= pend_flag_d;
      active_q      <= active_d;
      state_q       <= state_d;
      seg_out_q     <= seg_out_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_out     = seg_out_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;
  assign frm.pending = pend_flag_q;

endmodule
